sprite_rom_arbiter: RTL and testbench

- Shares one synchronous sprite ROM among NUM_REQ sprite requesters (tank, bullet, heart, tile renderers).
- Each requester asks for a burst of consecutive ROM words. The block grants bursts round-robin, drives the ROM address/enable, and routes returned pixel indices back with requester ID and last-beat tags.
- Sits between the sprite renderers and the sprite ROM, ahead of the palette lookup.

---
 rtl/sprite_arb_pkg.sv | 26 ++
 rtl/rr_picker.sv | 56 +++++
 rtl/sprite_rom_arbiter.sv | 144 ++++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_arb_pkg.sv
// Shared types for the sprite ROM arbiter: FSM state, response tag and ID width helper.
// Optional macro SPRITE_ARB_PRIO0_EN is consumed by rr_picker and sprite_rom_arbiter.
package sprite_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Tags carry the widest supported requester ID (NUM_REQ <= 8).
  localparam int MAX_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
    logic                last;
  } tag_t;

  function automatic int id_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority picker returning a one-hot winner and its index.
// With SPRITE_ARB_PRIO0_EN, requester 0 always wins and 1..NUM_REQ-1 rotate.
module rr_picker
  import sprite_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [ID_W-1:0]    pointer,
  output logic [NUM_REQ-1:0] onehot,
  output logic [ID_W-1:0]    idx
);

  logic [NUM_REQ-1:0] cand;
  logic               found;
  int                 pos;
  int                 base;

  assign cand = req & ~mask;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    base   = 0;
`ifdef SPRITE_ARB_PRIO0_EN
    base = (pointer == '0) ? 1 : int'(pointer);
    if (cand[0]) begin
      onehot[0] = 1'b1;
      found     = 1'b1;
    end
    for (int k = 0; k < NUM_REQ - 1; k++) begin
      pos = ((base - 1 + k) % (NUM_REQ - 1)) + 1;
      if (!found && cand[pos]) begin
        onehot[pos] = 1'b1;
        idx         = ID_W'(pos);
        found       = 1'b1;
      end
    end
`else
    base = int'(pointer);
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (base + k) % NUM_REQ;
      if (!found && cand[pos]) begin
        onehot[pos] = 1'b1;
        idx         = ID_W'(pos);
        found       = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin burst arbiter sharing one synchronous sprite ROM among NUM_REQ renderers.
// Define SPRITE_ARB_PRIO0_EN to give requester 0 fixed top priority.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int ADDR_W  = 12,
  parameter  int DATA_W  = 2,
  parameter  int LEN_W   = 4,
  parameter  int ROM_LAT = 1,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  output logic                      rom_en,
  input  logic [DATA_W-1:0]         rom_q,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_last,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [LEN_W-1:0]   remain_q, remain_d;
  logic [ADDR_W-1:0]  romAddr_q, romAddr_d;
  logic               romEn_q, romEn_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  tag_t               tag_q [ROM_LAT];
  tag_t               issueTag;

  logic [NUM_REQ-1:0] ownerMask;
  logic [NUM_REQ-1:0] pickOnehot;
  logic [ID_W-1:0]    pickIdx;
  logic [LEN_W-1:0]   pickLen;
  logic               grant;

  // The current owner is masked for its whole burst, including the gnt cycle.
  always_comb begin
    ownerMask = '0;
    if (state_q == BURST) ownerMask[owner_q] = 1'b1;
  end

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req     (req),
    .mask    (ownerMask),
    .pointer (ptr_q),
    .onehot  (pickOnehot),
    .idx     (pickIdx)
  );

  assign pickLen = req_len[int'(pickIdx)*LEN_W +: LEN_W];

  always_comb begin
    issueTag       = '0;
    issueTag.valid = romEn_q;
    issueTag.id    = MAX_ID_W'(owner_q);
    issueTag.last  = romEn_q && (remain_q == '0);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      remain_q  <= '0;
      romAddr_q <= '0;
      romEn_q   <= 1'b0;
      gnt_q     <= '0;
      for (int i = 0; i < ROM_LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      remain_q  <= remain_d;
      romAddr_q <= romAddr_d;
      romEn_q   <= romEn_d;
      gnt_q     <= gnt_d;
      tag_q[0]  <= issueTag;
      for (int i = 1; i < ROM_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    remain_d  = remain_q;
    romAddr_d = romAddr_q;
    romEn_d   = romEn_q;
    gnt_d     = '0;
    grant     = 1'b0;
    case (state_q)
      IDLE: grant = |pickOnehot;
      BURST: begin
        if (remain_q != '0) begin
          romAddr_d = romAddr_q + ADDR_W'(1);
          remain_d  = remain_q - LEN_W'(1);
        end else if (|pickOnehot) begin
          grant = 1'b1;
        end else begin
          state_d = IDLE;
          romEn_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      state_d   = BURST;
      gnt_d     = pickOnehot;
      romEn_d   = 1'b1;
      romAddr_d = req_addr[int'(pickIdx)*ADDR_W +: ADDR_W];
      owner_d   = pickIdx;
      remain_d  = (pickLen == '0) ? '0 : pickLen - LEN_W'(1);
`ifdef SPRITE_ARB_PRIO0_EN
      // A priority win by requester 0 leaves the rotation untouched.
      if (pickIdx != '0)
        ptr_d = (int'(pickIdx) == NUM_REQ - 1) ? ID_W'(1) : pickIdx + ID_W'(1);
`else
      ptr_d = (int'(pickIdx) == NUM_REQ - 1) ? '0 : pickIdx + ID_W'(1);
`endif
    end
  end

  always_comb begin
    gnt       = gnt_q;
    rom_en    = romEn_q;
    rom_addr  = romAddr_q;
    rsp_valid = tag_q[ROM_LAT-1].valid;
    rsp_id    = ID_W'(tag_q[ROM_LAT-1].id);
    rsp_last  = tag_q[ROM_LAT-1].last;
    rsp_data  = rom_q;
    busy      = (state_q != IDLE);
    for (int i = 0; i < ROM_LAT; i++) busy = busy | tag_q[i].valid;
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: vector table of single bursts plus
// round-robin, alternation and mid-burst reset sequences, against a small ROM model.
module tb_sprite_rom_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 2;
  localparam int LEN_W   = 4;
  localparam int ROM_LAT = 1;
  localparam int ID_W    = 2;

  logic                      vga_clk;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rom_addr;
  logic                      rom_en;
  logic [DATA_W-1:0]         rom_q;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic                      rsp_last;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy;

  int total;
  int bad;

  typedef struct {
    int               id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    int               beats;
  } vec_t;

  vec_t vecs [5];

  sprite_rom_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LEN_W   (LEN_W),
    .ROM_LAT (ROM_LAT)
  ) dut (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .gnt       (gnt),
    .rom_addr  (rom_addr),
    .rom_en    (rom_en),
    .rom_q     (rom_q),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_last  (rsp_last),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  function automatic logic [DATA_W-1:0] romWord(input logic [ADDR_W-1:0] a);
    return a[1:0] ^ a[5:4];
  endfunction

  // One-cycle synchronous ROM with a fixed address-derived content.
  always @(posedge vga_clk) begin
    if (rom_en) rom_q <= romWord(rom_addr);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkRsp(input string name, input int id, input logic last, input logic [DATA_W-1:0] data);
    checkOutput({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({name, " rsp_id"}, 32'(rsp_id), 32'(id));
    checkOutput({name, " rsp_last"}, 32'(rsp_last), 32'(last));
    checkOutput({name, " rsp_data"}, 32'(rsp_data), 32'(data));
  endtask

  task automatic applyStimulus(input int id, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len, input logic on);
    req[id] = on;
    req_addr[id*ADDR_W +: ADDR_W] = addr;
    req_len[id*LEN_W +: LEN_W] = len;
  endtask

  task automatic waitGrant(input string name, output logic got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge vga_clk);
      if (gnt != '0) got = 1'b1;
    end
    if (!got) checkOutput({name, " grant timeout"}, 32'd0, 32'd1);
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, " rom_en"}, 32'(rom_en), 32'd0);
    checkOutput({name, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({name, " busy"}, 32'(busy), 32'd0);
  endtask

  task automatic runVector(input int n, input vec_t v);
    logic             got;
    logic [ADDR_W-1:0] a;
    string            nm;
    nm = $sformatf("vec%0d", n);
    applyStimulus(v.id, v.addr, v.len, 1'b1);
    waitGrant(nm, got);
    if (got) begin
      checkOutput({nm, " gnt"}, 32'(gnt), 32'(1 << v.id));
      applyStimulus(v.id, v.addr, v.len, 1'b0);
      a = v.addr;
      for (int k = 0; k < v.beats; k++) begin
        checkOutput($sformatf("%s rom_en k%0d", nm, k), 32'(rom_en), 32'd1);
        checkOutput($sformatf("%s rom_addr k%0d", nm, k), 32'(rom_addr), 32'(a));
        checkOutput($sformatf("%s busy k%0d", nm, k), 32'(busy), 32'd1);
        if (k == 0) checkOutput({nm, " early rsp"}, 32'(rsp_valid), 32'd0);
        else        checkRsp($sformatf("%s k%0d", nm, k), v.id, 1'b0, romWord(a - ADDR_W'(1)));
        a = a + ADDR_W'(1);
        @(negedge vga_clk);
      end
      checkOutput({nm, " rom_en end"}, 32'(rom_en), 32'd0);
      checkRsp({nm, " final"}, v.id, 1'b1, romWord(a - ADDR_W'(1)));
      @(negedge vga_clk);
      checkIdle({nm, " after"});
    end else begin
      applyStimulus(v.id, v.addr, v.len, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int               order [5];
    logic             got;
    logic [ADDR_W-1:0] rrAddr [4];

    total    = 0;
    bad      = 0;
    reset_n  = 1'b0;
    req      = '0;
    req_addr = '0;
    req_len  = '0;
    order    = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) rrAddr[i] = ADDR_W'(12'h0A0 + i * 5);

    vecs[0] = '{id: 2, addr: 12'h010, len: 4'd3,  beats: 3};
    vecs[1] = '{id: 1, addr: 12'hFFE, len: 4'd4,  beats: 4};
    vecs[2] = '{id: 3, addr: 12'h5A0, len: 4'd0,  beats: 1};
    vecs[3] = '{id: 0, addr: 12'h123, len: 4'd1,  beats: 1};
    vecs[4] = '{id: 2, addr: 12'h200, len: 4'd15, beats: 15};

    // Reset values, with all four requesters already asking for one-beat bursts.
    for (int i = 0; i < 4; i++) applyStimulus(i, rrAddr[i], 4'd1, 1'b1);
    repeat (2) @(negedge vga_clk);
    checkOutput("reset gnt", 32'(gnt), 32'd0);
    checkOutput("reset rom_en", 32'(rom_en), 32'd0);
    checkOutput("reset rom_addr", 32'(rom_addr), 32'd0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset rsp_last", 32'(rsp_last), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    reset_n = 1'b1;

    // Round robin with no bubble between grants.
    for (int g = 0; g < 5; g++) begin
      @(negedge vga_clk);
      checkOutput($sformatf("rr gnt %0d", g), 32'(gnt), 32'(1 << order[g]));
      checkOutput($sformatf("rr rom_addr %0d", g), 32'(rom_addr), 32'(rrAddr[order[g]]));
      checkOutput($sformatf("rr rom_en %0d", g), 32'(rom_en), 32'd1);
      if (g > 0) checkRsp($sformatf("rr rsp %0d", g), order[g-1], 1'b1, romWord(rrAddr[order[g-1]]));
    end
    req = '0;
    @(negedge vga_clk);
    checkOutput("rr drain gnt", 32'(gnt), 32'd0);
    checkOutput("rr drain rom_en", 32'(rom_en), 32'd0);
    checkRsp("rr drain", 0, 1'b1, romWord(rrAddr[0]));
    @(negedge vga_clk);
    checkIdle("rr idle");

    for (int i = 0; i < 5; i++) runVector(i, vecs[i]);

    // Requesters 0 and 2 held continuously: owner masking makes them alternate.
    applyStimulus(0, 12'h300, 4'd1, 1'b1);
    applyStimulus(2, 12'h400, 4'd1, 1'b1);
    waitGrant("alt", got);
    if (got) begin
      for (int g = 0; g < 4; g++) begin
        if (g > 0) @(negedge vga_clk);
        checkOutput($sformatf("alt gnt %0d", g), 32'(gnt), (g % 2 == 0) ? 32'd1 : 32'd4);
      end
    end
    req = '0;
    repeat (3) @(negedge vga_clk);
    checkIdle("alt idle");

    // Reset in the middle of a long burst, then requesters 1 and 2 from pointer 0.
    applyStimulus(1, 12'h050, 4'd8, 1'b1);
    waitGrant("rst", got);
    applyStimulus(1, 12'h050, 4'd8, 1'b0);
    repeat (3) @(negedge vga_clk);
    checkOutput("rst pre rsp_valid", 32'(rsp_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst gnt", 32'(gnt), 32'd0);
    checkOutput("rst rom_en", 32'(rom_en), 32'd0);
    checkOutput("rst rom_addr", 32'(rom_addr), 32'd0);
    checkOutput("rst rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("rst rsp_last", 32'(rsp_last), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    applyStimulus(1, 12'h060, 4'd1, 1'b1);
    applyStimulus(2, 12'h070, 4'd1, 1'b1);
    @(negedge vga_clk);
    checkOutput("rst held rsp_valid", 32'(rsp_valid), 32'd0);
    reset_n = 1'b1;
    @(negedge vga_clk);
    checkOutput("rst first gnt", 32'(gnt), 32'd2);
    checkOutput("rst first addr", 32'(rom_addr), 32'h060);
    req[1] = 1'b0;
    @(negedge vga_clk);
    checkOutput("rst second gnt", 32'(gnt), 32'd4);
    checkRsp("rst second", 1, 1'b1, romWord(12'h060));
    req[2] = 1'b0;
    repeat (3) @(negedge vga_clk);
    checkIdle("rst idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
